// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin arbiter sharing one synchronous dmem port
// between requester 0 (load/store path) and requester 1 (debug/loader).
// One transaction at a time: grant in IDLE, drive dmem in ISSUE, and for
// reads wait READ_LATENCY edges in WAIT before returning q_dmem to the owner.
//
// Ports:
//   clock, reset          clock; asynchronous active-low reset
//   reqX, weX, addrX,     requester X request (held until gntX), write flag,
//   wdataX                address and write data
//   gntX                  one-cycle pulse: request X accepted
//   rvalidX, rdataX       one-cycle read-data-valid pulse and held read data
//   address_dmem, data,   dmem address, write data and write enable
//   wren
//   q_dmem                dmem read data
//   gnt_count0/1          16-bit saturating grant counters (only with
//                         DMEM_ARB_STATS_EN defined)
module dmem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]       gnt_count0,
    output logic [15:0]       gnt_count1,
`endif
    input  logic [DATA_W-1:0] q_dmem
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t     state, state_nx;
    logic       last;
    logic       owner;
    logic       owner_we;
    logic [2:0] cnt;

    // gnt is gated by reset so every output reads 0 while reset is held
    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        case (state)
            IDLE: begin
                gnt0 = reset & req0 & (~req1 | last);
                gnt1 = reset & req1 & (~req0 | ~last);
                state_nx = (gnt0 | gnt1) ? ISSUE : IDLE;
            end
            ISSUE:   state_nx = owner_we ? IDLE : WAIT;
            WAIT:    state_nx = (cnt == 3'd0) ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // the state register clears asynchronously, so wren drops with reset
    assign wren = (state == ISSUE) & owner_we;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last         <= 1'b1;
            owner        <= 1'b0;
            owner_we     <= 1'b0;
            cnt          <= 3'd0;
            address_dmem <= '0;
            data         <= '0;
            rvalid0      <= 1'b0;
            rvalid1      <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
        end else begin
            state   <= state_nx;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (gnt0 | gnt1) begin
                owner        <= gnt1;
                owner_we     <= gnt1 ? we1 : we0;
                address_dmem <= gnt1 ? addr1 : addr0;
                data         <= gnt1 ? wdata1 : wdata0;
                last         <= gnt1;
            end
            if (state == ISSUE)
                cnt <= 3'(READ_LATENCY - 1);
            else if (state == WAIT && cnt != 3'd0)
                cnt <= cnt - 3'd1;
            if (state == WAIT && cnt == 3'd0) begin
                if (owner) begin
                    rvalid1 <= 1'b1;
                    rdata1  <= q_dmem;
                end else begin
                    rvalid0 <= 1'b1;
                    rdata0  <= q_dmem;
                end
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_count0 <= 16'd0;
            gnt_count1 <= 16'd0;
        end else begin
            if (gnt0 && gnt_count0 != 16'hFFFF)
                gnt_count0 <= gnt_count0 + 16'd1;
            if (gnt1 && gnt_count1 != 16'hFFFF)
                gnt_count1 <= gnt_count1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: randomized and directed bench for dmem_port_arbiter,
// checked every cycle against a transaction-level model of the port.
module tb_dmem_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RL = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, wren;
    logic [DW-1:0] rdata0, rdata1, data, q_dmem;
    logic [AW-1:0] address_dmem;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   gnt_count0, gnt_count1;
`endif

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .address_dmem(address_dmem), .data(data), .wren(wren),
`ifdef DMEM_ARB_STATS_EN
        .gnt_count0(gnt_count0), .gnt_count1(gnt_count1),
`endif
        .q_dmem(q_dmem)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int failed = 0;

    // reference memory contents, also preloaded into the dmem model
    logic [DW-1:0] ref_mem [4096];

    // synchronous dmem with RL edges of read latency
    logic [DW-1:0] mem [4096];
    logic [DW-1:0] pipe [RL];
    logic          load = 1'b0;
    always @(posedge clock) begin
        if (load)
            for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
        else if (wren)
            mem[address_dmem] <= data;
        pipe[0] <= mem[address_dmem];
        for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end
    assign q_dmem = pipe[RL-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // transaction-level model: cycle index, when the port frees up, and the
    // single outstanding transaction's issue/response cycles
    int            t = 0;
    int            free_at, issue_at, rv_at;
    bit            last_m, issue_we, rv_who, e_win;
    bit            e_g0, e_g1, e_wren, e_rv0, e_rv1;
    bit            obs_g0, obs_g1;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data, rv_data;
    logic [DW-1:0] ref_rd [2];
    logic [15:0]   gc0, gc1;

    task automatic model_reset();
        last_m    = 1'b1;
        free_at   = 0;
        issue_at  = -1;
        rv_at     = -1;
        cur_addr  = '0;
        cur_data  = '0;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
        gc0       = '0;
        gc1       = '0;
    endtask

    task automatic compute();
        if (!reset) model_reset();
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (reset && t >= free_at && (req0 || req1)) begin
            e_win = (req0 && req1) ? !last_m : req1;
            e_g0  = !e_win;
            e_g1  = e_win;
        end
        e_wren = reset && t == issue_at && issue_we;
        e_rv0  = reset && t == rv_at && !rv_who;
        e_rv1  = reset && t == rv_at && rv_who;
        if (e_rv0 || e_rv1) ref_rd[rv_who] = rv_data;
    endtask

    task automatic cmp_all();
        check("gnt0", gnt0, e_g0);
        check("gnt1", gnt1, e_g1);
        check("wren", wren, e_wren);
        check("address_dmem", address_dmem, cur_addr);
        check("data", data, cur_data);
        check("rvalid0", rvalid0, e_rv0);
        check("rvalid1", rvalid1, e_rv1);
        check("rdata0", rdata0, ref_rd[0]);
        check("rdata1", rdata1, ref_rd[1]);
`ifdef DMEM_ARB_STATS_EN
        check("gnt_count0", gnt_count0, gc0);
        check("gnt_count1", gnt_count1, gc1);
`endif
    endtask

    task automatic commit();
        logic          w;
        logic [AW-1:0] a;
        if (e_g0 || e_g1) begin
            w        = e_win ? we1 : we0;
            a        = e_win ? addr1 : addr0;
            cur_addr = a;
            cur_data = e_win ? wdata1 : wdata0;
            last_m   = e_win;
            issue_at = t + 1;
            issue_we = w;
            if (e_win) gc1 = (gc1 == 16'hFFFF) ? gc1 : gc1 + 16'd1;
            else       gc0 = (gc0 == 16'hFFFF) ? gc0 : gc0 + 16'd1;
            if (w) begin
                ref_mem[a] = cur_data;
                free_at    = t + 2;
            end else begin
                rv_at   = t + 2 + RL;
                rv_who  = e_win;
                rv_data = ref_mem[a];
                free_at = t + 2 + RL;
            end
        end
        t++;
    endtask

    // one clock cycle: inputs are set just after posedge, checked at negedge
    task automatic cyc();
        @(negedge clock);
        obs_g0 = gnt0;
        obs_g1 = gnt1;
        compute();
        cmp_all();
        commit();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic set_req(input bit i, input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (i) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic req_until_gnt(input bit i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 1'b0;
        set_req(i, 1'b1, w, a, d);
        for (int n = 0; n < 100 && !got; n++) begin
            cyc();
            got = i ? e_g1 : e_g0;
        end
        if (!got) check("gnt_timeout", 32'd0, 32'd1);
        set_req(i, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic new_req(input bit i);
        set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
    endtask

    initial begin
        int n;
        bit order [6];
        for (int i = 0; i < 4096; i++) ref_mem[i] = $urandom;
        ref_mem[12'h010] = 32'hDEADBEEF;
        model_reset();
        load = 1'b1;
        @(posedge clock);
        #1;
        load = 1'b0;
        compute();
        cmp_all();
        @(posedge clock);
        #1;
        reset = 1'b1;

        // single read
        req_until_gnt(1'b0, 1'b0, 12'h010, '0);
        idle(6);
        check("single_read", rdata0, 32'hDEADBEEF);

        // write then readback through requester 1
        req_until_gnt(1'b1, 1'b1, 12'h0FF, 32'h12345678);
        req_until_gnt(1'b1, 1'b0, 12'h0FF, '0);
        idle(6);
        check("readback", rdata1, 32'h12345678);

        // withdrawal while a read is in flight
        req_until_gnt(1'b0, 1'b0, 12'h003, '0);
        set_req(1'b1, 1'b1, 1'b0, 12'h004, '0);
        idle(2);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        idle(6);

        // reset during WAIT
        req_until_gnt(1'b0, 1'b0, 12'h020, '0);
        cyc();
        reset = 1'b0;
        #1;
        compute();
        cmp_all();
        idle(2);
        reset = 1'b1;
        idle(6);

        // contention from reset: grants must alternate starting with 0
        set_req(1'b0, 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0);
        set_req(1'b1, 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0);
        n = 0;
        for (int k = 0; k < 200 && n < 6; k++) begin
            cyc();
            if (e_g0 || e_g1) begin
                order[n] = obs_g1;
                n++;
                set_req(e_win, 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0);
            end
        end
        check("contention_count", n, 6);
        for (int k = 0; k < 6; k++) check("grant_order", order[k], k & 1);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        idle(6);

        // random traffic with withdrawals and back-to-back requests
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (i ? e_g1 : e_g0) begin
                    if ($urandom_range(0, 1) == 1) new_req(i[0]);
                    else set_req(i[0], 1'b0, 1'b0, '0, '0);
                end else if (i ? req1 : req0) begin
                    if ($urandom_range(0, 19) == 0) set_req(i[0], 1'b0, 1'b0, '0, '0);
                end else if ($urandom_range(0, 9) < 3) begin
                    new_req(i[0]);
                end
            end
            cyc();
        end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
